// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, word-aligned byte-lane
// memory access, load extension and misaligned/illegal request detection.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [1:0]              off_q;
  logic                    en_q;
  logic                    mem_we_q;
  logic [3:0]              be_q;

  logic                    illegal;
  logic                    misaligned;
  logic [3:0]              be_next;
  logic [DATA_WIDTH-1:0]   wdata_next;
  logic [DATA_WIDTH-1:0]   lane;
  logic [DATA_WIDTH-1:0]   load_ext;

  // Reset kills the strobe in the reset cycle itself so an aborted store never writes
  assign mem_en = en_q & ~rst;
  assign mem_we = mem_we_q & ~rst;
  assign mem_be = rst ? 4'b0000 : be_q;

  // Request decode: legality, alignment, byte enables and replicated store data
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      misaligned = 1'b1;
    if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
      misaligned = 1'b1;
    case (req_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension of the returned word
  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Transaction FSM with all memory and response outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      en_q       <= 1'b0;
      mem_we_q   <= 1'b0;
      be_q       <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            off_q     <= req_addr[1:0];
            req_ready <= 1'b0;
            resp_err  <= illegal | misaligned;
            if (illegal || misaligned) begin
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              en_q      <= 1'b1;
              mem_we_q  <= req_we;
              be_q      <= be_next;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= wdata_next;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          en_q     <= 1'b0;
          mem_we_q <= 1'b0;
          be_q     <= 4'b0000;
          if (we_q) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          resp_rdata <= load_ext;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          resp_err  <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected memory
// accesses and responses; negedge monitors pop and compare.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } acc_t;

  resp_t exp_resp[$];
  acc_t  exp_acc[$];

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic        mon_on     = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  logic [31:0] ram [0:32767];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-lane word RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[16:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[16:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory-side monitor
  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_en) begin
        if (exp_acc.size() == 0) begin
          chk("unexpected_mem_en", 32'(mem_en), 32'h0);
        end else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk("mem_we", 32'(mem_we), 32'(a.we));
          chk("mem_addr", mem_addr, a.addr);
          chk("mem_be", 32'(mem_be), 32'(a.be));
          if (a.we) chk("mem_wdata", mem_wdata, a.wdata);
          chk("mem_cycle", 32'(cyc), 32'(a.cyc));
        end
      end else begin
        chk("mem_be_idle", 32'(mem_be), 32'h0);
      end
    end
  end

  // Response-side monitor
  always @(negedge clk) begin
    if (mon_on && resp_valid) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        resp_t r;
        r = exp_resp.pop_front();
        chk("resp_err", 32'(resp_err), 32'(r.err));
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(req_ready), 32'h1);
  endtask

  // Issue one request and queue its expected memory access and response
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] load_val,
                       input logic [3:0] be, input logic [31:0] mwdata);
    int t;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wait_ready();
    t = cyc;
    if (err) begin
      exp_resp.push_back('{1'b1, last_rdata, t + 1});
    end else begin
      exp_acc.push_back('{we, {addr[31:2], 2'b00}, be, mwdata, t + 1});
      if (we) begin
        exp_resp.push_back('{1'b0, last_rdata, t + 2});
      end else begin
        last_rdata = load_val;
        exp_resp.push_back('{1'b0, load_val, t + 3});
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_resp.size() != 0 || exp_acc.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pending_resp", 32'(exp_resp.size()), 32'h0);
    chk("pending_mem", 32'(exp_acc.size()), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 32'h0;
    mem_rdata = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Stores: word, byte with lane replication, upper address pass-through
    issue(1, 3'b010, 32'h0001_0004, 32'hDEAD_BEEF, 0, 0, 4'b1111, 32'hDEAD_BEEF);
    issue(1, 3'b000, 32'h0001_0007, 32'h0000_00A5, 0, 0, 4'b1000, 32'hA5A5_A5A5);
    issue(1, 3'b000, 32'h8000_0001, 32'h1234_567E, 0, 0, 4'b0010, 32'h7E7E_7E7E);
    issue(1, 3'b010, 32'h0001_0010, 32'h80FF_7F01, 0, 0, 4'b1111, 32'h80FF_7F01);

    // Loads with extension from word 0x80FF7F01
    issue(0, 3'b000, 32'h0001_0013, 0, 0, 32'hFFFF_FF80, 4'b1000, 0);
    issue(0, 3'b100, 32'h0001_0013, 0, 0, 32'h0000_0080, 4'b1000, 0);
    issue(0, 3'b001, 32'h0001_0012, 0, 0, 32'hFFFF_80FF, 4'b1100, 0);
    issue(0, 3'b101, 32'h0001_0010, 0, 0, 32'h0000_7F01, 4'b0011, 0);
    issue(0, 3'b000, 32'h0001_0010, 0, 0, 32'h0000_0001, 4'b0001, 0);
    issue(0, 3'b010, 32'h0001_0004, 0, 0, 32'hA5AD_BEEF, 4'b1111, 0);
    issue(0, 3'b001, 32'h0001_0006, 0, 0, 32'hFFFF_A5AD, 4'b1100, 0);

    // Store after load keeps resp_rdata; halfword store into upper lanes
    issue(1, 3'b001, 32'h0001_0012, 32'hABCD_1234, 0, 0, 4'b1100, 32'h1234_1234);
    issue(0, 3'b010, 32'h0001_0010, 0, 0, 32'h1234_7F01, 4'b1111, 0);

    // Misaligned and illegal requests never touch memory
    issue(0, 3'b010, 32'h0001_0002, 0, 1, 0, 0, 0);
    issue(1, 3'b001, 32'h0001_0001, 32'hFFFF_FFFF, 1, 0, 0, 0);
    issue(0, 3'b101, 32'h0001_0003, 0, 1, 0, 0, 0);
    issue(1, 3'b100, 32'h0001_0010, 32'h0000_0000, 1, 0, 0, 0);
    issue(1, 3'b101, 32'h0001_0010, 32'h0000_0000, 1, 0, 0, 0);
    issue(0, 3'b011, 32'h0001_0010, 0, 1, 0, 0, 0);
    issue(0, 3'b110, 32'h0001_0010, 0, 1, 0, 0, 0);
    drain();

    // Reset during ISSUE of a store: no write, no response
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0001_0010;
    req_wdata = 32'hCAFE_F00D; req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_issue_mem_en", 32'(mem_en), 32'h0);
    chk("rst_issue_mem_we", 32'(mem_we), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    chk("post_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("post_rst_rdata", resp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    issue(0, 3'b010, 32'h0001_0010, 0, 0, 32'h1234_7F01, 4'b1111, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
